// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/DM memory port arbiter.
// Imported by mem_arb_lat_cnt and mem_port_arbiter.
package mem_arb_pkg;

    typedef enum logic {S_IDLE, S_BUSY} arb_state_e;
    typedef enum logic {OWN_IF, OWN_DM} arb_owner_e;

    // Counter width: latency values up to 15 fit.
    localparam int CNT_W = 4;

endpackage

// File: rtl/mem_arb_lat_cnt.sv
// Memory latency counter for the arbiter.
// Load on issue, count down while busy, and flag zero on the response cycle.
module mem_arb_lat_cnt
    import mem_arb_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             zero
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between fetch (IF) and data (DM); DM wins ties.
// Optional IF anti-starvation guard: define MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic              dm_wdone,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT - 1);

    arb_state_e       state;
    arb_owner_e       owner;
    logic             own_we;
    logic [CNT_W-1:0] cnt;
    logic             cnt_zero;
    logic             can_grant;
    logic             resp;
    logic             force_if;
    logic             pick_dm;
    logic             pick_if;
    logic             any_gnt;

    mem_arb_lat_cnt u_lat_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (any_gnt),
        .load_val (LAT_LOAD),
        .dec      (state == S_BUSY && !cnt_zero),
        .cnt      (cnt),
        .zero     (cnt_zero)
    );

    // Reset masks everything so no output moves while reset is high.
    assign resp      = !reset && (state == S_BUSY) && cnt_zero;
    assign can_grant = !reset && ((state == S_IDLE) || ((state == S_BUSY) && cnt_zero));

`ifdef MEM_ARB_STARVE_GUARD_EN
    logic [CNT_W-1:0] starve_cnt;

    assign force_if = if_req && (starve_cnt == CNT_W'(STARVE_MAX));

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (if_gnt) begin
            starve_cnt <= '0;
        end else if (dm_gnt && if_req) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end
`else
    assign force_if = 1'b0;
`endif

    assign pick_dm = dm_req && !force_if;
    assign pick_if = if_req && !pick_dm;
    assign dm_gnt  = can_grant && pick_dm;
    assign if_gnt  = can_grant && pick_if;
    assign any_gnt = dm_gnt || if_gnt;

    assign mem_re = if_gnt || (dm_gnt && !dm_we);
    assign mem_we = dm_gnt && dm_we;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        if (dm_gnt) begin
            mem_addr  = dm_addr;
            mem_wdata = dm_we ? dm_wdata : '0;
        end else if (if_gnt) begin
            mem_addr = if_addr;
        end
    end

    assign if_rvalid = resp && (owner == OWN_IF);
    assign dm_rvalid = resp && (owner == OWN_DM) && !own_we;
    assign dm_wdone  = resp && (owner == OWN_DM) && own_we;
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign dm_rdata  = dm_rvalid ? mem_rdata : '0;
    assign busy      = !reset && (state == S_BUSY);

    // A grant in the response cycle keeps the port busy for back-to-back issue.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            owner  <= OWN_IF;
            own_we <= 1'b0;
        end else if (any_gnt) begin
            state  <= S_BUSY;
            owner  <= dm_gnt ? OWN_DM : OWN_IF;
            own_we <= dm_gnt && dm_we;
        end else if (resp) begin
            state <= S_IDLE;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic vs a
// cycle-timestamp transaction model. Follows MEM_ARB_STARVE_GUARD_EN like the RTL.
module tb_mem_port_arbiter;

    localparam int LAT  = 2;
    localparam int SMAX = 4;
`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        if_req, dm_req, dm_we;
    logic [63:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid, dm_wdone, mem_re, mem_we, busy;
    logic [63:0] if_rdata, dm_rdata, mem_addr, mem_wdata;

    logic        b_if_req;
    logic [63:0] b_if_addr, b_mem_rdata;
    logic        b_if_gnt, b_if_rvalid, b_dm_gnt, b_dm_rvalid, b_dm_wdone, b_mem_re, b_mem_we, b_busy;
    logic [63:0] b_if_rdata, b_dm_rdata, b_mem_addr, b_mem_wdata;

    mem_port_arbiter #(.MEM_LAT(LAT), .STARVE_MAX(SMAX)) u_dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_wdone(dm_wdone), .dm_rdata(dm_rdata),
        .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(SMAX)) u_lat1 (
        .clk(clk), .reset(reset),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt), .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
        .dm_req(1'b0), .dm_we(1'b0), .dm_addr(64'h0), .dm_wdata(64'h0),
        .dm_gnt(b_dm_gnt), .dm_rvalid(b_dm_rvalid), .dm_wdone(b_dm_wdone), .dm_rdata(b_dm_rdata),
        .mem_re(b_mem_re), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata), .busy(b_busy)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Transaction model: one outstanding access, response due at a cycle timestamp.
    bit pv;
    int pc;
    bit pd, pw;
    int starve;
    bit e_resp, e_gif, e_gdm;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic sample();
        bit can, force_if, rv_if, rv_dm, wd_dm;
        @(negedge clk);
        if (reset) begin
            e_resp = 1'b0;
            e_gif  = 1'b0;
            e_gdm  = 1'b0;
        end else begin
            e_resp   = pv && (pc == cyc);
            can      = !pv || e_resp;
            force_if = GUARD && (starve >= SMAX) && if_req;
            e_gdm    = can && dm_req && !force_if;
            e_gif    = can && if_req && !e_gdm;
        end
        rv_if = e_resp && !pd;
        rv_dm = e_resp && pd && !pw;
        wd_dm = e_resp && pd && pw;
        check("if_gnt", if_gnt, e_gif);
        check("dm_gnt", dm_gnt, e_gdm);
        check("mem_re", mem_re, e_gif || (e_gdm && !dm_we));
        check("mem_we", mem_we, e_gdm && dm_we);
        check("mem_addr", mem_addr, e_gdm ? dm_addr : (e_gif ? if_addr : 64'h0));
        check("mem_wdata", mem_wdata, (e_gdm && dm_we) ? dm_wdata : 64'h0);
        check("if_rvalid", if_rvalid, rv_if);
        check("if_rdata", if_rdata, rv_if ? mem_rdata : 64'h0);
        check("dm_rvalid", dm_rvalid, rv_dm);
        check("dm_rdata", dm_rdata, rv_dm ? mem_rdata : 64'h0);
        check("dm_wdone", dm_wdone, wd_dm);
        check("busy", busy, !reset && pv);
    endtask

    task automatic advance();
        @(posedge clk);
        if (reset) begin
            pv     = 1'b0;
            starve = 0;
        end else begin
            if (e_resp) pv = 1'b0;
            if (e_gdm || e_gif) begin
                pv = 1'b1;
                pc = cyc + LAT;
                pd = e_gdm;
                pw = e_gdm && dm_we;
            end
            if (GUARD) begin
                if (e_gif) starve = 0;
                else if (e_gdm && if_req) starve++;
            end
        end
        #1;
        cyc++;
    endtask

    task automatic tick();
        sample();
        advance();
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        bit exp_if, exp_dm;
        reset = 1'b1;
        if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
        mem_rdata = '0;
        b_if_req = 1'b0; b_if_addr = '0; b_mem_rdata = '0;
        pv = 1'b0; starve = 0;
        tick();
        tick();
        reset = 1'b0;
        sample();
        check("rst_busy", busy, 64'h0);
        check("rst_b_busy", b_busy, 64'h0);
        advance();

        // Single fetch
        if_req = 1'b1; if_addr = 64'h40;
        sample();
        check("t1_if_gnt", if_gnt, 64'h1);
        check("t1_mem_addr", mem_addr, 64'h40);
        advance();
        if_req = 1'b0;
        tick();
        mem_rdata = 64'h8B020020;
        sample();
        check("t1_if_rvalid", if_rvalid, 64'h1);
        check("t1_if_rdata", if_rdata, 64'h8B020020);
        advance();
        mem_rdata = '0;

        // Simultaneous IF + DM load: DM first, IF at the response cycle
        if_req = 1'b1; if_addr = 64'h44;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h100;
        sample();
        check("t2_dm_gnt", dm_gnt, 64'h1);
        check("t2_if_wait", if_gnt, 64'h0);
        advance();
        dm_req = 1'b0;
        tick();
        mem_rdata = 64'h1234;
        sample();
        check("t2_dm_rvalid", dm_rvalid, 64'h1);
        check("t2_dm_rdata", dm_rdata, 64'h1234);
        check("t2_if_gnt", if_gnt, 64'h1);
        advance();
        if_req = 1'b0; mem_rdata = '0;
        tick();
        mem_rdata = 64'h5678;
        sample();
        check("t2_if_rvalid", if_rvalid, 64'h1);
        check("t2_if_rdata", if_rdata, 64'h5678);
        advance();
        mem_rdata = '0;

        // Store
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 64'h8; dm_wdata = 64'hDEAD;
        sample();
        check("t3_mem_we", mem_we, 64'h1);
        check("t3_mem_wdata", mem_wdata, 64'hDEAD);
        advance();
        dm_req = 1'b0; dm_we = 1'b0; dm_wdata = '0;
        sample();
        check("t3_early_wdone", dm_wdone, 64'h0);
        advance();
        sample();
        check("t3_wdone", dm_wdone, 64'h1);
        check("t3_no_rvalid", dm_rvalid, 64'h0);
        advance();

        // Reset in the middle of an access
        if_req = 1'b1; if_addr = 64'h60;
        sample();
        check("t4_if_gnt", if_gnt, 64'h1);
        advance();
        if_req = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        mem_rdata = 64'hBAD;
        sample();
        check("t4_no_rvalid", if_rvalid, 64'h0);
        check("t4_busy", busy, 64'h0);
        advance();
        mem_rdata = '0;

        // Starvation: both held high
        pulse_reset();
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h200;
        if_req = 1'b1; if_addr = 64'h80;
        for (int c = 0; c < 12; c++) begin
            exp_if = GUARD && (c == 8);
            exp_dm = (c % 2 == 0) && !exp_if;
            sample();
            check($sformatf("t5_if_gnt_c%0d", c), if_gnt, {63'h0, exp_if});
            check($sformatf("t5_dm_gnt_c%0d", c), dm_gnt, {63'h0, exp_dm});
            advance();
        end
        dm_req = 1'b0; if_req = 1'b0;
        for (int c = 0; c < LAT + 1; c++) tick();

        // Back-to-back fetch on the MEM_LAT=1 instance
        b_if_req = 1'b1; b_if_addr = 64'h0; b_mem_rdata = 64'hA0;
        for (int k = 0; k < 5; k++) begin
            sample();
            check($sformatf("t6_gnt_k%0d", k), b_if_gnt, (k < 3) ? 64'h1 : 64'h0);
            if (k < 3) check($sformatf("t6_addr_k%0d", k), b_mem_addr, 64'(4 * k));
            check($sformatf("t6_rvalid_k%0d", k), b_if_rvalid, (k >= 1 && k <= 3) ? 64'h1 : 64'h0);
            if (k >= 1 && k <= 3) check($sformatf("t6_rdata_k%0d", k), b_if_rdata, 64'(160 + k));
            if (k == 4) check("t6_idle", b_busy, 64'h0);
            advance();
            if (k == 2) b_if_req = 1'b0;
            b_if_addr   = 64'(4 * (k + 1));
            b_mem_rdata = 64'(160 + k + 1);
        end
        b_if_req = 1'b0;

        // Randomized traffic with occasional resets and abandoned requests
        for (int n = 0; n < 400; n++) begin
            reset     = ($urandom_range(0, 39) == 0);
            mem_rdata = {$urandom, $urandom};
            tick();
            if (dm_req && (e_gdm || $urandom_range(0, 19) == 0)) dm_req = 1'b0;
            if (!dm_req && $urandom_range(0, 2) == 0) begin
                dm_req   = 1'b1;
                dm_we    = 1'($urandom_range(0, 1));
                dm_addr  = {$urandom, $urandom};
                dm_wdata = {$urandom, $urandom};
            end
            if (if_req && (e_gif || $urandom_range(0, 19) == 0)) if_req = 1'b0;
            if (!if_req && $urandom_range(0, 1) == 0) begin
                if_req  = 1'b1;
                if_addr = {$urandom, $urandom};
            end
        end
        reset = 1'b0; dm_req = 1'b0; if_req = 1'b0;
        for (int c = 0; c < LAT + 1; c++) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
